psram_master: RTL and testbench

PSRAM_MASTER -- requirements
Module: psram_master

---
 rtl/psram_master.sv | 173 +++++++++++++++++
 tb/tb_psram_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_master.sv
// -----------------------------------------------------------------------------
// psram_master
//   Single-outstanding asynchronous PSRAM/SRAM access sequencer. A request is
//   accepted in IDLE. The access then runs through three phases, SETUP, ACCESS
//   and RECOVER, and the length of each phase is set by a parameter. Every
//   ram_* pin is driven straight from a register.
//
// Parameters
//   T_SETUP  cycles address/CE are valid before the OE/WE strobe (1..15)
//   T_ACC    cycles OE/WE are held low                            (2..15)
//   T_REC    cycles CE is held high after the strobe              (1..15)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready == IDLE)
//   req_we, req_addr,
//   req_wdata, req_be          request fields (be[1]=upper, be[0]=lower)
//   rsp_valid, rsp_rdata       one-cycle read-data strobe and held read data
//   ram_addr, ram_ce, ram_oe,
//   ram_we, ram_ub, ram_lb     memory address and active-low strobes
//   ram_data_o, ram_data_oe,
//   ram_data_i                 data bus, split; the tristate lives above
//   busy                       high in any state other than IDLE
// -----------------------------------------------------------------------------
module psram_master #(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_ACC   = 4,
  parameter int unsigned T_REC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [21:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [21:0] ram_addr,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic        ram_ub,
  output logic        ram_lb,
  output logic [15:0] ram_data_o,
  output logic        ram_data_oe,
  input  logic [15:0] ram_data_i,
  output logic        busy
);

  if (T_SETUP < 1 || T_SETUP > 15 || T_ACC < 2 || T_ACC > 15 ||
      T_REC < 1 || T_REC > 15) begin : g_param_range
    $error("psram_master: timing parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic [21:0] addr_q;
  logic        ce_q, oe_q, wen_q, ub_q, lb_q;
  logic [15:0] dout_q;
  logic        doe_q;

  // Each output register is loaded with the value it must have in the state
  // being entered. This keeps all pins registered and still lines them up
  // with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      ub_q        <= 1'b1;
      lb_q        <= 1'b1;
      dout_q      <= '0;
      doe_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready_q gates acceptance, so the first edge after reset release
          // only raises ready and does not accept a request.
          if (req_valid && ready_q) begin
            state_q <= SETUP;
            cnt_q   <= 4'(T_SETUP);
            we_q    <= req_we;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            addr_q  <= req_addr;
            ce_q    <= 1'b0;
            ub_q    <= ~req_be[1];
            lb_q    <= ~req_be[0];
            dout_q  <= req_wdata;
            doe_q   <= req_we;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd1) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(T_ACC);
            oe_q    <= we_q;
            wen_q   <= ~we_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd1) begin
            state_q <= RECOVER;
            cnt_q   <= 4'(T_REC);
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            if (!we_q) begin
              rsp_rdata_q <= ram_data_i;
              rsp_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RECOVER: begin
          // Write data stays driven for the first RECOVER cycle as hold time.
          doe_q <= 1'b0;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_addr    = addr_q;
  assign ram_ce      = ce_q;
  assign ram_oe      = oe_q;
  assign ram_we      = wen_q;
  assign ram_ub      = ub_q;
  assign ram_lb      = lb_q;
  assign ram_data_o  = dout_q;
  assign ram_data_oe = doe_q;

endmodule

// File: tb/tb_psram_master.sv
// -----------------------------------------------------------------------------
// tb_psram_master
//   Bench for psram_master. dut1 uses the default timing and sits on a
//   byte-lane RAM model. dut2 uses T_SETUP=2, T_ACC=6, T_REC=1 and sits on an
//   address-derived read-only model. Expected read data is pushed to a
//   scoreboard queue when a request is issued. It is popped and compared when
//   rsp_valid appears. The pin waveforms of every access are captured as
//   per-cycle bit vectors and compared against the timing expected from the
//   parameters.
// -----------------------------------------------------------------------------
module tb_psram_master;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        req_valid, req_we;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rv_in1, rv_in2;

  logic        rdy1, rsp1, ce1, oe1, we1, ub1, lb1, doe1, busy1;
  logic [15:0] rdata1, dout1, rd1;
  logic [21:0] addr1;
  logic        rdy2, rsp2, ce2, oe2, we2, ub2, lb2, doe2, busy2;
  logic [15:0] rdata2, dout2, rd2;
  logic [21:0] addr2;

  assign rv_in1 = req_valid & ~sel;
  assign rv_in2 = req_valid & sel;

  psram_master dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_in1), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp1), .rsp_rdata(rdata1), .ram_addr(addr1), .ram_ce(ce1),
    .ram_oe(oe1), .ram_we(we1), .ram_ub(ub1), .ram_lb(lb1), .ram_data_o(dout1),
    .ram_data_oe(doe1), .ram_data_i(rd1), .busy(busy1)
  );

  psram_master #(.T_SETUP(2), .T_ACC(6), .T_REC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_in2), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp2), .rsp_rdata(rdata2), .ram_addr(addr2), .ram_ce(ce2),
    .ram_oe(oe2), .ram_we(we2), .ram_ub(ub2), .ram_lb(lb2), .ram_data_o(dout2),
    .ram_data_oe(doe2), .ram_data_i(rd2), .busy(busy2)
  );

  // Monitored view of whichever DUT is selected
  logic        m_ready, m_rsp, m_ce, m_oe, m_we, m_ub, m_lb, m_doe, m_busy;
  logic [15:0] m_rdata, m_dout;
  logic [21:0] m_addr;
  assign m_ready = sel ? rdy2   : rdy1;
  assign m_rsp   = sel ? rsp2   : rsp1;
  assign m_ce    = sel ? ce2    : ce1;
  assign m_oe    = sel ? oe2    : oe1;
  assign m_we    = sel ? we2    : we1;
  assign m_ub    = sel ? ub2    : ub1;
  assign m_lb    = sel ? lb2    : lb1;
  assign m_doe   = sel ? doe2   : doe1;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_rdata = sel ? rdata2 : rdata1;
  assign m_dout  = sel ? dout2  : dout1;
  assign m_addr  = sel ? addr2  : addr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial contents of the dut1 RAM model
  function automatic logic [15:0] base(input logic [7:0] i);
    return (i == 8'h10) ? 16'hA55A : {i, ~i};
  endfunction

  // dut1 RAM model: 256 words indexed by addr[7:0], byte-lane writes
  logic [15:0] mem [256];
  bit          mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= base(8'(i));
      mem_init <= 1'b1;
    end else if (!ce1 && !we1 && doe1) begin
      mem[addr1[7:0]] <= {ub1 ? mem[addr1[7:0]][15:8] : dout1[15:8],
                          lb1 ? mem[addr1[7:0]][7:0]  : dout1[7:0]};
    end
  end
  assign rd1 = (!ce1 && !oe1) ? mem[addr1[7:0]] : '0;

  // dut2 model: read data derived from the address
  assign rd2 = (!ce2 && !oe2) ? (addr2[15:0] ^ 16'h5A5A) : '0;

  typedef struct packed {
    logic [15:0] d;
    logic        care;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] shadow [256];
  int          n_tests;
  int          n_fail;
  bit          chain;
  int unsigned last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] span(input int unsigned lo, input int unsigned n);
    logic [15:0] v;
    v = '0;
    for (int unsigned i = lo; i < lo + n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_accept(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, " accept timeout"}, 32'(m_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Issue one access and capture its pin waveform until it is ready again.
  // With hold=1, req_valid stays high after the accept, and the next call
  // checks the accept-to-accept period.
  task automatic xfer(input bit s, input bit we, input logic [21:0] a,
                      input logic [15:0] wd, input logic [1:0] be,
                      input bit hold, input string tag);
    int unsigned ts, ta, tr, w;
    logic [15:0] ce_v, oe_v, we_v, ub_v, lb_v, doe_v, rv_v, nrdy_v, busy_v;
    bit          ok, addr_ok, data_ok;
    sb_t         e;
    ts = s ? 2 : 1;
    ta = s ? 6 : 4;
    tr = s ? 1 : 2;
    w  = ts + ta + tr;
    if (!we) begin
      sb_q.push_back('{d: (s ? (a[15:0] ^ 16'h5A5A) : shadow[a[7:0]]), care: (be != 2'b00)});
    end else if (!s) begin
      if (be[1]) shadow[a[7:0]][15:8] = wd[15:8];
      if (be[0]) shadow[a[7:0]][7:0]  = wd[7:0];
    end
    @(posedge clk);
    #1;
    sel = s; req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    wait_accept(tag, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    if (chain) check({tag, " period"}, cyc - last_acc, w + 1);
    last_acc = cyc;
    if (!hold) req_valid = 1'b0;
    ce_v = '0; oe_v = '0; we_v = '0; ub_v = '0; lb_v = '0;
    doe_v = '0; rv_v = '0; nrdy_v = '0; busy_v = '0;
    addr_ok = 1'b1; data_ok = 1'b1;
    for (int k = 0; k < int'(w); k++) begin
      @(negedge clk);
      if (k == 2) begin
        // Fields change in flight; the DUT must not use them.
        req_we = 1'b1; req_addr = 22'h0000AA; req_wdata = 16'hDEAD; req_be = 2'b11;
      end
      ce_v[k]   = ~m_ce;
      oe_v[k]   = ~m_oe;
      we_v[k]   = ~m_we;
      ub_v[k]   = ~m_ub;
      lb_v[k]   = ~m_lb;
      doe_v[k]  = m_doe;
      rv_v[k]   = m_rsp;
      nrdy_v[k] = ~m_ready;
      busy_v[k] = m_busy;
      if (!m_ce && m_addr !== a) addr_ok = 1'b0;
      if (m_doe && m_dout !== wd) data_ok = 1'b0;
      if (m_rsp) begin
        if (sb_q.size() == 0) begin
          check({tag, " unexpected rsp"}, 32'(m_rsp), 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.care) check({tag, " rdata"}, 32'(m_rdata), 32'(e.d));
        end
      end
    end
    check({tag, " ce"}, 32'(ce_v), 32'(span(0, ts + ta)));
    check({tag, " oe"}, 32'(oe_v), we ? 32'd0 : 32'(span(ts, ta)));
    check({tag, " we"}, 32'(we_v), we ? 32'(span(ts, ta)) : 32'd0);
    check({tag, " data_oe"}, 32'(doe_v), we ? 32'(span(0, ts + ta + 1)) : 32'd0);
    check({tag, " rsp_valid"}, 32'(rv_v), we ? 32'd0 : 32'(span(ts + ta, 1)));
    check({tag, " ub"}, 32'(ub_v), be[1] ? 32'(span(0, ts + ta)) : 32'd0);
    check({tag, " lb"}, 32'(lb_v), be[0] ? 32'(span(0, ts + ta)) : 32'd0);
    check({tag, " ready low"}, 32'(nrdy_v), 32'(span(0, w)));
    check({tag, " busy"}, 32'(busy_v), 32'(span(0, w)));
    check({tag, " addr"}, 32'(addr_ok), 32'd1);
    if (we) check({tag, " wdata"}, 32'(data_ok), 32'd1);
    check({tag, " sb drained"}, 32'(sb_q.size()), 32'd0);
    chain = hold;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit rv_seen;
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; chain = 1'b0;
    n_tests = 0; n_fail = 0; last_acc = 0;
    for (int i = 0; i < 256; i++) shadow[i] = base(8'(i));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(rdy1), 32'd0);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst strobes", 32'({ce1, oe1, we1, ub1, lb1}), 32'h1F);
    check("rst data_oe", 32'(doe1), 32'd0);
    check("rst rsp_valid", 32'(rsp1), 32'd0);
    check("rst rdata", 32'(rdata1), 32'd0);
    check("rst addr", 32'(addr1), 32'd0);
    check("rst dout", 32'(dout1), 32'd0);
    check("rst ready2", 32'(rdy2), 32'd0);
    #1 rst_n = 1'b1;
    check("ready before edge", 32'(rdy1), 32'd0);
    @(posedge clk);
    #1;
    check("ready after release", 32'(rdy1), 32'd1);

    xfer(1'b0, 1'b1, 22'h123456, 16'hBEEF, 2'b11, 1'b0, "wr full");
    xfer(1'b0, 1'b0, 22'h000010, 16'h0000, 2'b11, 1'b0, "rd 0x10");
    xfer(1'b0, 1'b0, 22'h123456, 16'h0000, 2'b11, 1'b0, "rd back");
    xfer(1'b0, 1'b1, 22'h000020, 16'h3456, 2'b11, 1'b0, "wr 0x20");
    xfer(1'b0, 1'b1, 22'h000020, 16'h12FF, 2'b10, 1'b0, "wr upper");
    xfer(1'b0, 1'b0, 22'h000020, 16'h0000, 2'b11, 1'b0, "rd upper");
    xfer(1'b0, 1'b0, 22'h000021, 16'h0000, 2'b00, 1'b0, "rd be00");

    xfer(1'b0, 1'b0, 22'h000010, 16'h0000, 2'b11, 1'b1, "b2b0");
    xfer(1'b0, 1'b0, 22'h000056, 16'h0000, 2'b11, 1'b1, "b2b1");
    xfer(1'b0, 1'b0, 22'h000020, 16'h0000, 2'b11, 1'b0, "b2b2");

    // Reset during the second ACCESS cycle of a write
    @(posedge clk);
    #1;
    sel = 1'b0; req_we = 1'b1; req_addr = 22'h000040; req_wdata = 16'h7777;
    req_be = 2'b11; req_valid = 1'b1;
    wait_accept("rst mid", ok);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst mid ce", 32'(ce1), 32'd1);
    check("rst mid we", 32'(we1), 32'd1);
    check("rst mid data_oe", 32'(doe1), 32'd0);
    check("rst mid busy", 32'(busy1), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    rv_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rv_seen = rv_seen | rsp1;
    end
    check("rst mid no rsp", 32'(rv_seen), 32'd0);
    check("rst mid ready", 32'(rdy1), 32'd1);
    chain = 1'b0;

    xfer(1'b0, 1'b1, 22'h000030, 16'hCAFE, 2'b11, 1'b0, "post rst wr");
    xfer(1'b0, 1'b0, 22'h000030, 16'h0000, 2'b11, 1'b0, "post rst rd");

    xfer(1'b1, 1'b0, 22'h3FFFFF, 16'h0000, 2'b11, 1'b1, "p2 rd top");
    xfer(1'b1, 1'b0, 22'h000001, 16'h0000, 2'b11, 1'b0, "p2 rd next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
